clkdiv_ratio_ctrl: RTL and testbench

Runtime-programmable even-ratio clock-enable divider with a controller that sequences ratio changes.
- New divide ratios arrive over a valid/ready config handshake.
- A new ratio is applied only at a period boundary, so div_out never produces a runt pulse.
- Generates divN/tick strobes for downstream logic that needs a selectable divN rate instead of fixed div2/div4/div6.

---
 rtl/clkdiv_ratio_ctrl_pkg.sv | 28 ++
 rtl/clkdiv_ratio_ctrl_if.sv | 23 ++
 rtl/clkdiv_ratio_ctrl_core.sv | 37 +++
 rtl/clkdiv_ratio_ctrl.sv | 119 +++++++++++
 tb/tb_clkdiv_ratio_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_ratio_ctrl_pkg.sv
// Shared types and helpers for the programmable clock-enable divider.
// Defining CLKDIV_ODD_EN makes odd ratios >= 3 legal.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    localparam int unsigned CLKDIV_STOP = 32'd0;

    function automatic logic is_legal_div(input int unsigned n);
        logic ok;
        if (n == CLKDIV_STOP) begin
            ok = 1'b1;
        end else begin
`ifdef CLKDIV_ODD_EN
            ok = (n >= 32'd2);
`else
            // A nonzero even ratio is necessarily >= 2.
            ok = (n[0] == 1'b0);
`endif
        end
        return ok;
    endfunction

endpackage

// File: rtl/clkdiv_ratio_ctrl_if.sv
// Config request channel of the divider controller: valid/ready plus error pulse.
interface clkdiv_ratio_ctrl_if #(
    parameter int CNT_W = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clkdiv_ratio_ctrl_core.sv
// Period counter and waveform decode for a ratio supplied by the controller.
module clkdiv_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic [CNT_W-1:0] ratio,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             div_out,
    output logic             period_tick
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic [CNT_W-1:0] w_half;

    assign w_last = (r_cnt == (ratio - CNT_W'(1)));
    // For odd ratios ratio>>1 equals (ratio-1)/2, giving the sub-50% duty for free.
    assign w_half = ratio >> 1;

    // Period counter: restarts on load, holds zero while stopped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (load || !run || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt         = r_cnt;
    assign div_out     = run && (r_cnt >= CNT_W'(1)) && (r_cnt <= w_half);
    assign period_tick = run && w_last;

endmodule

// File: rtl/clkdiv_ratio_ctrl.sv
// Ratio controller: accepts config requests and applies them only at period boundaries.
// Build option: CLKDIV_ODD_EN enables odd ratios >= 3.
module clkdiv_ratio_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    clkdiv_ratio_ctrl_if.slave   cfg,
    output logic                 div_out,
    output logic                 period_tick,
    output logic [CNT_W-1:0]     active_div,
    output logic                 pending
);
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_active_div;
    logic [CNT_W-1:0] w_active_nxt;
    logic [CNT_W-1:0] r_pending_div;
    logic [CNT_W-1:0] w_pending_nxt;
    logic             r_cfg_err;
    logic             w_load;
    logic             w_xfer;
    logic             w_legal;
    logic             w_stop_req;
    logic             w_run;
    logic             w_boundary;
    logic [CNT_W-1:0] w_cnt;

    assign w_run      = (r_state != IDLE);
    assign w_xfer     = cfg.cfg_valid && cfg.cfg_ready;
    assign w_legal    = is_legal_div(32'(cfg.cfg_div));
    assign w_stop_req = (cfg.cfg_div == CNT_W'(CLKDIV_STOP));
    assign w_boundary = w_run && (w_cnt == (r_active_div - CNT_W'(1)));

    clkdiv_core #(.CNT_W(CNT_W)) u_core (
        .clk         (clk),
        .resetn      (resetn),
        .run         (w_run),
        .ratio       (r_active_div),
        .load        (w_load),
        .cnt         (w_cnt),
        .div_out     (div_out),
        .period_tick (period_tick)
    );

    // Controller state, ratio registers and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_active_div  <= '0;
            r_pending_div <= '0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_active_div  <= w_active_nxt;
            r_pending_div <= w_pending_nxt;
            r_cfg_err     <= w_xfer && !w_legal;
        end
    end

    // Next-state logic; illegal requests fall through with everything unchanged.
    always_comb begin
        w_state_nxt   = r_state;
        w_active_nxt  = r_active_div;
        w_pending_nxt = r_pending_div;
        w_load        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && w_legal && !w_stop_req) begin
                    w_state_nxt  = RUN;
                    w_active_nxt = cfg.cfg_div;
                    w_load       = 1'b1;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            RUN: begin
                if (w_xfer && w_legal) begin
                    if (!w_boundary) begin
                        w_state_nxt   = PEND;
                        w_pending_nxt = cfg.cfg_div;
                    end else if (w_stop_req) begin
                        w_state_nxt  = IDLE;
                        w_active_nxt = '0;
                    end else begin
                        w_active_nxt = cfg.cfg_div;
                        w_load       = 1'b1;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            PEND: begin
                if (!w_boundary) begin
                    w_state_nxt = PEND;
                end else if (r_pending_div == CNT_W'(CLKDIV_STOP)) begin
                    w_state_nxt  = IDLE;
                    w_active_nxt = '0;
                end else begin
                    w_state_nxt  = RUN;
                    w_active_nxt = r_pending_div;
                    w_load       = 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_active_nxt = '0;
            end
        endcase
    end

    assign cfg.cfg_ready = (r_state != PEND);
    assign cfg.cfg_err   = r_cfg_err;
    assign active_div    = r_active_div;
    assign pending       = (r_state == PEND);

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Self-checking bench for clkdiv_ratio_ctrl: vector table, corner sequences, random vs model.
module tb_clkdiv_ratio_ctrl;
    localparam int CNT_W = 8;

    logic             clk;
    logic             resetn;
    logic             div_out;
    logic             period_tick;
    logic [CNT_W-1:0] active_div;
    logic             pending;

    clkdiv_ratio_ctrl_if #(.CNT_W(CNT_W)) if_cfg ();

    clkdiv_ratio_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg         (if_cfg.slave),
        .div_out     (div_out),
        .period_tick (period_tick),
        .active_div  (active_div),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: current ratio (0 = stopped), position in period, queued ratio (-1 = none).
    int m_ratio = 0;
    int m_phase = 0;
    int m_pend  = -1;
    bit m_err   = 1'b0;

    typedef struct {
        bit          rstn;
        bit          vld;
        logic [7:0]  div;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rstn, bit vld, int div, bit rdy, bit err,
                                bit dout, bit tk, bit pnd, int act);
        vec_t v;
        v.rstn = rstn;
        v.vld  = vld;
        v.div  = 8'(div);
        v.exp  = {rdy, err, dout, tk, pnd, 8'(act)};
        return v;
    endfunction

    function automatic bit legal(int d);
`ifdef CLKDIV_ODD_EN
        return d != 1;
`else
        return (d % 2) == 0;
`endif
    endfunction

    function automatic logic [12:0] model_out();
        bit rdy, tk, dout, pnd;
        rdy  = (m_pend < 0);
        pnd  = (m_pend >= 0);
        tk   = (m_ratio != 0) && (m_phase == m_ratio - 1);
        dout = (m_ratio != 0) && (m_phase >= 1) && (m_phase <= m_ratio / 2);
        return {rdy, m_err, dout, tk, pnd, 8'(m_ratio)};
    endfunction

    function automatic logic [12:0] dut_out();
        return {if_cfg.cfg_ready, if_cfg.cfg_err, div_out, period_tick, pending, active_div};
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit xfer, ok, at_end;
        int d;
        d = int'(if_cfg.cfg_div);
        if (!resetn) begin
            m_ratio = 0; m_phase = 0; m_pend = -1; m_err = 1'b0;
        end else begin
            xfer   = if_cfg.cfg_valid && (m_pend < 0);
            ok     = legal(d);
            at_end = (m_ratio != 0) && (m_phase == m_ratio - 1);
            m_err  = xfer && !ok;
            if (m_ratio == 0) begin
                if (xfer && ok && d != 0) begin
                    m_ratio = d; m_phase = 0;
                end
            end else if (m_pend >= 0) begin
                if (at_end) begin
                    m_ratio = m_pend; m_phase = 0; m_pend = -1;
                end else begin
                    m_phase++;
                end
            end else if (xfer && ok && at_end) begin
                m_ratio = d; m_phase = 0;
            end else begin
                if (xfer && ok) m_pend = d;
                m_phase = at_end ? 0 : m_phase + 1;
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit rstn, bit vld, int div);
        resetn           = rstn;
        if_cfg.cfg_valid = vld;
        if_cfg.cfg_div   = 8'(div);
    endtask

    task automatic step_check(string name);
        @(posedge clk);
        model_step();
        #1;
        check(name, 32'(dut_out()), 32'(model_out()));
    endtask

    initial begin
        int n;
        drive(0, 0, 0);

        // Directed table: 4 start, illegal 1, bypass to 8, pend to 2, pend stop.
        tbl.push_back(mk(0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,1,4, 1,0,0,0,0,4));
        tbl.push_back(mk(1,0,0, 1,0,1,0,0,4));
        tbl.push_back(mk(1,0,0, 1,0,1,0,0,4));
        tbl.push_back(mk(1,0,0, 1,0,0,1,0,4));
        tbl.push_back(mk(1,0,0, 1,0,0,0,0,4));
        tbl.push_back(mk(1,0,0, 1,0,1,0,0,4));
        tbl.push_back(mk(1,1,1, 1,1,1,0,0,4));
        tbl.push_back(mk(1,0,0, 1,0,0,1,0,4));
        tbl.push_back(mk(1,1,8, 1,0,0,0,0,8));
        tbl.push_back(mk(1,0,0, 1,0,1,0,0,8));
        tbl.push_back(mk(1,1,2, 0,0,1,0,1,8));
        tbl.push_back(mk(1,1,6, 0,0,1,0,1,8));
        tbl.push_back(mk(1,0,0, 0,0,1,0,1,8));
        tbl.push_back(mk(1,0,0, 0,0,0,0,1,8));
        tbl.push_back(mk(1,0,0, 0,0,0,0,1,8));
        tbl.push_back(mk(1,0,0, 0,0,0,1,1,8));
        tbl.push_back(mk(1,0,0, 1,0,0,0,0,2));
        tbl.push_back(mk(1,0,0, 1,0,1,1,0,2));
        tbl.push_back(mk(1,0,0, 1,0,0,0,0,2));
        tbl.push_back(mk(1,1,0, 0,0,1,1,1,2));
        tbl.push_back(mk(1,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,0, 1,0,0,0,0,0));

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rstn, tbl[i].vld, int'(tbl[i].div));
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // Running at 6, request 2 at cnt=1: old period finishes intact.
        drive(1, 1, 6);
        step_check("seqA_start");
        drive(1, 0, 0);
        n = 0;
        while (m_phase != 1 && n < 20) begin step_check("seqA_wait"); n++; end
        drive(1, 1, 2);
        step_check("seqA_req");
        check("seqA_pend_rdy", 32'({pending, if_cfg.cfg_ready}), 32'(2'b10));
        drive(1, 0, 0);
        n = 0;
        while (active_div != 8'd2 && n < 20) begin step_check("seqA_run"); n++; end
        check("seqA_switch_cycles", 32'(n), 32'd4);
        check("seqA_after", 32'({pending, active_div}), 32'({1'b0, 8'd2}));

        // Running at 6, stop at cnt=2: three more cycles then idle.
        drive(1, 1, 6);
        step_check("seqB_req6");
        drive(1, 0, 0);
        n = 0;
        while (!(active_div == 8'd6 && m_phase == 2) && n < 30) begin step_check("seqB_wait"); n++; end
        drive(1, 1, 0);
        step_check("seqB_stop");
        drive(1, 0, 0);
        n = 0;
        while (active_div != 8'd0 && n < 20) begin step_check("seqB_run"); n++; end
        check("seqB_stop_cycles", 32'(n), 32'd3);
        check("seqB_idle", 32'({div_out, period_tick, active_div}), 32'd0);

        // Reset asserted while a change is pending at cnt=3.
        drive(1, 1, 6);
        step_check("seqC_start");
        drive(1, 0, 0);
        step_check("seqC_cnt1");
        drive(1, 1, 2);
        step_check("seqC_req");
        drive(1, 0, 0);
        step_check("seqC_cnt3");
        drive(0, 0, 0);
        step_check("seqC_reset");
        check("seqC_reset_vals", 32'(dut_out()), 32'(13'h1000));
        drive(1, 0, 0);
        step_check("seqC_post1");
        step_check("seqC_post2");
        check("seqC_discarded", 32'(active_div), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit v;
            int d;
            r = ($urandom % 400) != 0;
            v = ($urandom % 4) == 0;
            d = (($urandom % 16) == 0) ? int'($urandom % 256) : int'($urandom_range(0, 12));
            drive(r, v, d);
            step_check("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
